sdram_arbiter: RTL and testbench

- Shares the single Avalon-MM SDRAM master between two requesters: the VGA pixel fetcher (port V, reads only) and the renderer (port R, reads and writes).
- VGA has priority because it is the real-time display path. A streak counter guarantees the renderer forward progress.
- Outstanding reads are tagged in order, so each readdatavalid beat is routed back to the requester that issued it.

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/arb_tag_fifo.sv | 51 +++++
 rtl/sdram_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM arbiter slice.
// Requester identities double as the 1-bit read tag values.
package sdram_arb_pkg;

    typedef enum logic {
        REQ_VGA    = 1'b0,
        REQ_RENDER = 1'b1
    } requester_t;

    localparam int ADDR_W_DEF = 26;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of 1-bit read tags, one entry per outstanding SDRAM read.
// The extra pointer bit tells a full FIFO from an empty one.
module arb_tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign dout_o  = mem_q[rd_ptr_q[PTR_W-2:0]];

    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;
    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= din_i;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SDRAM: VGA reads have priority,
// a streak counter forces renderer access, and read beats are routed by tag.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TAG_DEPTH      = 16,
    parameter int VGA_STREAK_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic [ADDR_W-1:0] v_address_i,
    input  logic              v_read_i,
    output logic              v_waitrequest_o,
    output logic [DATA_W-1:0] v_readdata_o,
    output logic              v_readdatavalid_o,

    input  logic [ADDR_W-1:0] r_address_i,
    input  logic              r_read_i,
    input  logic              r_write_i,
    input  logic [DATA_W-1:0] r_writedata_i,
    output logic              r_waitrequest_o,
    output logic [DATA_W-1:0] r_readdata_o,
    output logic              r_readdatavalid_o,

    output logic [ADDR_W-1:0] m_address_o,
    output logic              m_read_o,
    output logic              m_write_o,
    output logic [DATA_W-1:0] m_writedata_o,
    input  logic              m_waitrequest_i,
    input  logic [DATA_W-1:0] m_readdata_i,
    input  logic              m_readdatavalid_i,

    output logic              err_underflow_o
);

    localparam int STREAK_W = $clog2(VGA_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VGA_STREAK_MAX);

    requester_t          gnt_q, grant;
    logic                locked_q, locked_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                err_q, err_d;

    logic reqR, rRead, rWrite;
    logic eligV, eligR;
    logic grantV;
    logic cmdRead, cmdWrite;
    logic accept;
    logic tagFull, tagEmpty, headTag;
    logic tagPush, tagPop;

    // A simultaneous read+write from the renderer is treated as a read only.
    assign reqR   = r_read_i | r_write_i;
    assign rRead  = r_read_i;
    assign rWrite = r_write_i & ~r_read_i;

    assign eligV = v_read_i & ~tagFull;
    assign eligR = (rRead & ~tagFull) | rWrite;

    always_comb begin
        grant = gnt_q;
        if (!locked_q) begin
            if (eligV && eligR) begin
                grant = (streak_q == STREAK_MAX) ? REQ_RENDER : REQ_VGA;
            end else if (eligV) begin
                grant = REQ_VGA;
            end else if (eligR) begin
                grant = REQ_RENDER;
            end
        end
    end

    assign grantV   = (grant == REQ_VGA);
    assign cmdRead  = grantV ? eligV : (rRead & ~tagFull);
    assign cmdWrite = ~grantV & rWrite;

    assign m_read_o      = rst_ni & cmdRead;
    assign m_write_o     = rst_ni & cmdWrite;
    assign m_address_o   = grantV ? v_address_i : r_address_i;
    assign m_writedata_o = r_writedata_i;

    // A read blocked by a full tag FIFO stalls even while its port holds the grant.
    assign v_waitrequest_o = ~rst_ni | ~grantV | (v_read_i & tagFull) | m_waitrequest_i;
    assign r_waitrequest_o = ~rst_ni | grantV | (rRead & tagFull) | m_waitrequest_i;

    assign accept  = (m_read_o | m_write_o) & ~m_waitrequest_i;
    assign tagPush = accept & m_read_o;
    assign tagPop  = rst_ni & m_readdatavalid_i & ~tagEmpty;

    assign v_readdatavalid_o = tagPop & ~headTag;
    assign r_readdatavalid_o = tagPop & headTag;
    assign v_readdata_o      = m_readdata_i;
    assign r_readdata_o      = m_readdata_i;
    assign err_underflow_o   = err_q;

    assign locked_d = (m_read_o | m_write_o) & m_waitrequest_i;
    assign err_d    = err_q | (m_readdatavalid_i & tagEmpty);

    always_comb begin
        streak_d = streak_q;
        if (!reqR || (accept && !grantV)) begin
            streak_d = '0;
        end else if (accept && grantV && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q    <= REQ_VGA;
            locked_q <= 1'b0;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            gnt_q    <= grant;
            locked_q <= locked_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tagPush),
        .pop_i   (tagPop),
        .din_i   (~grantV),
        .dout_o  (headTag),
        .full_o  (tagFull),
        .empty_o (tagEmpty)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a queue-based reference model
// checked every cycle plus literal expectations per scenario.
module tb_sdram_arbiter;

    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int SMAX  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] v_address, r_address, m_address;
    logic          v_read, v_waitrequest, v_readdatavalid;
    logic [DW-1:0] v_readdata, r_readdata, r_writedata, m_writedata, m_readdata;
    logic          r_read, r_write, r_waitrequest, r_readdatavalid;
    logic          m_read, m_write, m_waitrequest, m_readdatavalid;
    logic          err_underflow;

    int checks = 0;
    int errors = 0;

    sdram_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TAG_DEPTH      (DEPTH),
        .VGA_STREAK_MAX (SMAX)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .v_address_i       (v_address),
        .v_read_i          (v_read),
        .v_waitrequest_o   (v_waitrequest),
        .v_readdata_o      (v_readdata),
        .v_readdatavalid_o (v_readdatavalid),
        .r_address_i       (r_address),
        .r_read_i          (r_read),
        .r_write_i         (r_write),
        .r_writedata_i     (r_writedata),
        .r_waitrequest_o   (r_waitrequest),
        .r_readdata_o      (r_readdata),
        .r_readdatavalid_o (r_readdatavalid),
        .m_address_o       (m_address),
        .m_read_o          (m_read),
        .m_write_o         (m_write),
        .m_writedata_o     (m_writedata),
        .m_waitrequest_i   (m_waitrequest),
        .m_readdata_i      (m_readdata),
        .m_readdatavalid_i (m_readdatavalid),
        .err_underflow_o   (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkString(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic vRd, input logic [AW-1:0] vAddr,
                                 input logic rRd, input logic rWr, input logic [AW-1:0] rAddr,
                                 input logic [DW-1:0] rData, input logic mWait,
                                 input logic mRdv, input logic [DW-1:0] mData);
        v_read          = vRd;
        v_address       = vAddr;
        r_read          = rRd;
        r_write         = rWr;
        r_address       = rAddr;
        r_writedata     = rData;
        m_waitrequest   = mWait;
        m_readdatavalid = mRdv;
        m_readdata      = mData;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: outstanding read owners in issue order, streak, stall hold
    bit            tagQ[$];
    int            streak = 0;
    bit            holdR = 1'b0;
    bit            stuck = 1'b0;
    bit            errSticky = 1'b0;
    string         acceptStr = "";
    logic [DW-1:0] vBeats[$];
    logic [DW-1:0] rBeats[$];

    task automatic clearLogs();
        acceptStr = "";
        vBeats.delete();
        rBeats.delete();
    endtask

    always @(negedge clk) begin
        bit full, vOk, rWr, rOk, ownR, expRd, expWr, acc, head, hasHead;
        if (!rst_n) begin
            checkOutput("rst_m_read", m_read, 0);
            checkOutput("rst_m_write", m_write, 0);
            checkOutput("rst_v_rdv", v_readdatavalid, 0);
            checkOutput("rst_r_rdv", r_readdatavalid, 0);
            checkOutput("rst_v_wait", v_waitrequest, 1);
            checkOutput("rst_r_wait", r_waitrequest, 1);
            checkOutput("rst_err", err_underflow, 0);
            tagQ.delete();
            streak = 0;
            holdR = 1'b0;
            stuck = 1'b0;
            errSticky = 1'b0;
        end else begin
            full  = (tagQ.size() >= DEPTH);
            vOk   = v_read && !full;
            rWr   = r_write && !r_read;
            rOk   = (r_read && !full) || rWr;
            if (stuck)            ownR = holdR;
            else if (vOk && rOk)  ownR = (streak >= SMAX);
            else if (vOk)         ownR = 1'b0;
            else if (rOk)         ownR = 1'b1;
            else                  ownR = holdR;
            expRd = ownR ? (r_read && !full) : vOk;
            expWr = ownR && rWr;
            acc   = (expRd || expWr) && !m_waitrequest;

            checkOutput("m_read", m_read, expRd);
            checkOutput("m_write", m_write, expWr);
            if (expRd || expWr)
                checkOutput("m_address", m_address, ownR ? r_address : v_address);
            if (expWr)
                checkOutput("m_writedata", m_writedata, r_writedata);
            checkOutput("v_wait", v_waitrequest, (!ownR && !(v_read && full)) ? m_waitrequest : 1'b1);
            checkOutput("r_wait", r_waitrequest, (ownR && !(r_read && full)) ? m_waitrequest : 1'b1);

            hasHead = m_readdatavalid && (tagQ.size() > 0);
            head    = hasHead ? tagQ[0] : 1'b0;
            checkOutput("v_rdv", v_readdatavalid, hasHead && !head);
            checkOutput("r_rdv", r_readdatavalid, hasHead && head);
            if (hasHead) begin
                checkOutput("v_readdata", v_readdata, m_readdata);
                checkOutput("r_readdata", r_readdata, m_readdata);
            end
            checkOutput("err_underflow", err_underflow, errSticky);

            if (v_read && !v_waitrequest) acceptStr = {acceptStr, "V"};
            if ((r_read || r_write) && !r_waitrequest) acceptStr = {acceptStr, "R"};
            if (v_readdatavalid) vBeats.push_back(v_readdata);
            if (r_readdatavalid) rBeats.push_back(r_readdata);

            if (hasHead) void'(tagQ.pop_front());
            if (m_readdatavalid && !hasHead) errSticky = 1'b1;
            if (acc && expRd) tagQ.push_back(ownR);
            if (!(r_read || r_write) || (acc && ownR)) streak = 0;
            else if (acc && !ownR && streak < SMAX) streak++;
            stuck = (expRd || expWr) && m_waitrequest;
            holdR = ownR;
        end
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single VGA read with a 3-cycle return
        $display("[TB] single VGA read");
        clearLogs();
        applyStimulus(1, 26'h0001000, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t1_m_read", m_read, 1);
        checkOutput("t1_m_address", m_address, 26'h0001000);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        #2;
        checkOutput("t1_v_rdv", v_readdatavalid, 1);
        checkOutput("t1_v_readdata", v_readdata, 32'hDEADBEEF);
        checkOutput("t1_r_rdv", r_readdatavalid, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkString("t1_accepts", acceptStr, "V");

        // Continuous contention: streak lets the renderer in every 9th acceptance
        $display("[TB] streak contention");
        clearLogs();
        for (int i = 0; i <= 18; i++) begin
            applyStimulus(i < 18, 26'h2000 + 26'(i), i < 18, 0, 26'h3000 + 26'(i), 0,
                          0, i > 0, 32'h100 + 32'(i));
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkString("t2_pattern", acceptStr, "VVVVVVVVRVVVVVVVVR");
        checkOutput("t2_r_beats", rBeats.size(), 2);
        if (rBeats.size() == 2) begin
            checkOutput("t2_r_beat0", rBeats[0], 32'h109);
            checkOutput("t2_r_beat1", rBeats[1], 32'h112);
        end

        // Stalled renderer write keeps the bus stable and blocks VGA
        $display("[TB] stalled write");
        clearLogs();
        applyStimulus(0, 26'h4000, 0, 1, 26'h0000200, 32'hCAFEF00D, 1, 0, 0);
        #2;
        checkOutput("t3_m_write0", m_write, 1);
        checkOutput("t3_m_address0", m_address, 26'h0000200);
        tick();
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1, 26'h4000, 0, 1, 26'h0000200, 32'hCAFEF00D, 1, 0, 0);
            #2;
            checkOutput("t3_m_write", m_write, 1);
            checkOutput("t3_m_address", m_address, 26'h0000200);
            checkOutput("t3_m_writedata", m_writedata, 32'hCAFEF00D);
            checkOutput("t3_v_wait", v_waitrequest, 1);
            checkOutput("t3_m_read", m_read, 0);
            tick();
        end
        applyStimulus(1, 26'h4000, 0, 1, 26'h0000200, 32'hCAFEF00D, 0, 0, 0);
        #2;
        checkOutput("t3_accept_r_wait", r_waitrequest, 0);
        checkOutput("t3_accept_v_wait", v_waitrequest, 1);
        tick();
        applyStimulus(1, 26'h4000, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t3_v_m_read", m_read, 1);
        checkOutput("t3_v_m_address", m_address, 26'h4000);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkString("t3_accepts", acceptStr, "RV");

        // Interleaved reads return to their issuers in order
        $display("[TB] interleaved tags");
        clearLogs();
        applyStimulus(1, 26'h10, 0, 0, 0, 0, 0, 0, 0);          tick();
        applyStimulus(0, 0, 1, 0, 26'h20, 0, 0, 0, 0);          tick();
        applyStimulus(1, 26'h30, 0, 0, 0, 0, 0, 0, 0);          tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA0001);    tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hBBBB0002);    tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hCCCC0003);    tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);               tick();
        checkString("t4_accepts", acceptStr, "VRV");
        checkOutput("t4_v_count", vBeats.size(), 2);
        checkOutput("t4_r_count", rBeats.size(), 1);
        if (vBeats.size() == 2 && rBeats.size() == 1) begin
            checkOutput("t4_v_first", vBeats[0], 32'hAAAA0001);
            checkOutput("t4_r_only", rBeats[0], 32'hBBBB0002);
            checkOutput("t4_v_second", vBeats[1], 32'hCCCC0003);
        end

        // Full tag FIFO blocks reads but not writes
        $display("[TB] full tag fifo");
        clearLogs();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 26'h5000 + 26'(i), 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(1, 26'h5010, 0, 1, 26'h300, 32'h12345678, 0, 0, 0);
        #2;
        checkOutput("t5_v_wait_full", v_waitrequest, 1);
        checkOutput("t5_m_read_full", m_read, 0);
        checkOutput("t5_m_write", m_write, 1);
        checkOutput("t5_r_wait", r_waitrequest, 0);
        checkOutput("t5_m_address", m_address, 26'h300);
        tick();
        applyStimulus(1, 26'h5010, 0, 0, 0, 0, 0, 1, 32'h77);
        #2;
        checkOutput("t5_v_wait_pop", v_waitrequest, 1);
        checkOutput("t5_v_rdv_pop", v_readdatavalid, 1);
        tick();
        applyStimulus(1, 26'h5010, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t5_m_read_after", m_read, 1);
        checkOutput("t5_v_wait_after", v_waitrequest, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h600 + 32'(i));
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkString("t5_accepts", acceptStr, "VVVVVVVVVVVVVVVVRV");
        checkOutput("t5_no_underflow", err_underflow, 0);

        // Stray beat after reset sets the sticky underflow flag
        $display("[TB] underflow");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
        #2;
        checkOutput("t6_v_rdv", v_readdatavalid, 0);
        checkOutput("t6_r_rdv", r_readdatavalid, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t6_err_set", err_underflow, 1);
        tick();
        tick();
        checkOutput("t6_err_held", err_underflow, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_err_cleared", err_underflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
